alu_share_arb: RTL and testbench
================================

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 The block SHALL have parameter CTRL_W, default 17, ALU control-word width, matching the control encodings in defines.svh.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-006 req0_ready / req1_ready  output  1  requester N operation accepted this cycle.
REQ-007 req0_ctrl / req1_ctrl  input  CTRL_W  ALU control word.
REQ-008 req0_x1, req0_x2 / req1_x1, req1_x2  input  DATA_W  operands.
REQ-009 alu_x1, alu_x2  output  DATA_W  operands to the shared ALU.
REQ-010 alu_ctrl  output  CTRL_W  control word to the shared ALU.
REQ-011 alu_out  input  DATA_W  combinational ALU result.
REQ-012 rsp_valid  output  1  response register holds a result.
REQ-013 rsp_ready  input  1  consumer takes the response.
REQ-014 rsp_id  output  1  requester that owns the response (0 or 1).
REQ-015 rsp_data  output  DATA_W  registered ALU result.
REQ-016 stat0_cnt / stat1_cnt  output  16  accepted-operation counts per requester.

Function
REQ-017 can_accept SHALL be (!rsp_valid) or (rsp_valid and rsp_ready).
REQ-018 With can_accept=1 and exactly one reqN_valid=1, that requester SHALL be granted.
REQ-019 With both valid, grant SHALL go to the requester pointed to by the 1-bit priority pointer prio.
REQ-020 reqN_ready SHALL be 1 only when can_accept=1, reqN_valid=1 and N is granted; never both readies in one cycle.
REQ-021 Ready SHALL be combinational and SHALL NOT depend on the requester's own ready.
REQ-022 After each accept, prio SHALL point to the non-granted requester; prio SHALL be unchanged when nothing is accepted.
REQ-023 In the accept cycle, alu_x1/alu_x2/alu_ctrl SHALL equal the granted requester's fields; otherwise all three SHALL be 0.
REQ-024 On accept, the next edge SHALL load rsp_data<=alu_out, rsp_id<=grant, rsp_valid<=1.
REQ-025 Latency SHALL be 1 cycle from accept to rsp_valid; throughput SHALL be 1 operation per cycle when rsp_ready=1.
REQ-026 While rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id SHALL hold and no request SHALL be accepted.
REQ-027 On a response handshake with no new accept in the same cycle, rsp_valid SHALL drop to 0 next cycle.
REQ-028 A simultaneous drain and accept in one cycle SHALL replace the response with no bubble.
REQ-029 Requesters SHALL hold fields stable while valid and not ready; the block SHALL NOT register request fields.

Reset
REQ-030 While rst=1, the block SHALL set rsp_valid=0, rsp_id=0, rsp_data=0, prio=0 (req0 preferred), and stat0_cnt=stat1_cnt=0 on each clock edge.
REQ-031 While rst=1, req0_ready and req1_ready SHALL be 0 and alu_* SHALL be 0.
REQ-032 Reset asserted with a pending response SHALL discard it; the response SHALL NOT be presented after reset releases.

Configuration
REQ-033 With ALU_ARB_STATS_EN defined, statN_cnt SHALL increment by 1 on each accept from requester N.
REQ-034 With ALU_ARB_STATS_EN defined, statN_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-035 Without ALU_ARB_STATS_EN, stat0_cnt and stat1_cnt SHALL be constant 0, no counter flops SHALL exist, and the ports SHALL remain.

Verification
REQ-036 Reset, then req0 add x1=5 x2=7 alone, rsp_ready=1 -> req0_ready=1 in cycle 0; next cycle rsp_valid=1, rsp_id=0, rsp_data=12.
REQ-037 Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 from reset; rsp_id sequence 0,1,0,1 with no idle cycle.
REQ-038 rsp_valid=1 with rsp_ready=0 for 3 cycles, req1 sub 9-4 waiting -> rsp_data/rsp_id held, req1_ready=0; on the cycle rsp_ready=1, req1_ready=1 and next rsp_data=5, rsp_id=1.
REQ-039 Reset asserted in the cycle after an accept -> rsp_valid=0 and prio=0 after the edge; first post-reset dual request granted to req0.
REQ-040 ALU_ARB_STATS_EN defined, 70000 accepts from req0 -> stat0_cnt=16'hFFFF, stat1_cnt=0; macro undefined, same stimulus -> both counts 0.

Source files
------------

// File: rtl/alu_share_arb.sv
// Two-requester front end for one shared combinational ALU: round-robin grant,
// one-deep response register. Optional per-requester counters: ALU_ARB_STATS_EN.
module alu_share_arb #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_x1,
  input  logic [DATA_W-1:0] req0_x2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_x1,
  input  logic [DATA_W-1:0] req1_x2,
  output logic [DATA_W-1:0] alu_x1,
  output logic [DATA_W-1:0] alu_x2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [15:0]       stat0_cnt,
  output logic [15:0]       stat1_cnt
);

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              prio_q, prio_d;
  logic              can_accept_s;
  logic              grant_s;
  logic              accept_s;

  assign can_accept_s = !rsp_valid_q || rsp_ready;
  assign accept_s     = !rst && can_accept_s && (req0_valid || req1_valid);

  // Grant selection: a lone requester wins, contention is settled by prio_q.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = prio_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign req0_ready = accept_s && (grant_s == 1'b0);
  assign req1_ready = accept_s && (grant_s == 1'b1);

  // Shared ALU operand mux; driven to zero whenever nothing is accepted.
  always_comb begin
    alu_x1   = {DATA_W{1'b0}};
    alu_x2   = {DATA_W{1'b0}};
    alu_ctrl = {CTRL_W{1'b0}};
    if (accept_s) begin
      alu_x1   = grant_s ? req1_x1   : req0_x1;
      alu_x2   = grant_s ? req1_x2   : req0_x2;
      alu_ctrl = grant_s ? req1_ctrl : req0_ctrl;
    end else begin
      alu_x1   = {DATA_W{1'b0}};
      alu_x2   = {DATA_W{1'b0}};
      alu_ctrl = {CTRL_W{1'b0}};
    end
  end

  // Response register next state; an accept overrides a same-cycle drain.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    prio_d      = prio_q;
    if (accept_s) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_s;
      rsp_data_d  = alu_out;
      prio_d      = ~grant_s;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Response and priority state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= {DATA_W{1'b0}};
      prio_q      <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      prio_q      <= prio_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat0_q, stat0_d;
  logic [15:0] stat1_q, stat1_d;

  // Saturating accept counters.
  always_comb begin
    stat0_d = stat0_q;
    stat1_d = stat1_q;
    if (req0_ready && (stat0_q != 16'hFFFF)) begin
      stat0_d = stat0_q + 16'd1;
    end else begin
      stat0_d = stat0_q;
    end
    if (req1_ready && (stat1_q != 16'hFFFF)) begin
      stat1_d = stat1_q + 16'd1;
    end else begin
      stat1_d = stat1_q;
    end
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat0_q <= 16'd0;
      stat1_q <= 16'd0;
    end else begin
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
    end
  end

  assign stat0_cnt = stat0_q;
  assign stat1_cnt = stat1_q;
`else
  assign stat0_cnt = 16'd0;
  assign stat1_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomised bench for alu_share_arb with a transaction-level reference model
// plus directed scenarios pinning the model to hand-computed values.
module tb_alu_share_arb;
  localparam int DW = 32;
  localparam int CW = 17;
  localparam logic [CW-1:0] OP_ADD = 17'd1;
  localparam logic [CW-1:0] OP_SUB = 17'd2;
  localparam logic [CW-1:0] OP_AND = 17'd4;
  localparam logic [CW-1:0] OP_XOR = 17'd8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [CW-1:0] req0_ctrl = '0, req1_ctrl = '0;
  logic [DW-1:0] req0_x1 = '0, req0_x2 = '0, req1_x1 = '0, req1_x2 = '0;
  logic [DW-1:0] alu_x1, alu_x2, alu_out;
  logic [CW-1:0] alu_ctrl;
  logic rsp_valid, rsp_id;
  logic rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [15:0] stat0_cnt, stat1_cnt;

  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_share_arb #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_x1(req0_x1), .req0_x2(req0_x2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_x1(req1_x1), .req1_x2(req1_x2),
    .alu_x1(alu_x1), .alu_x2(alu_x2), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .stat0_cnt(stat0_cnt), .stat1_cnt(stat1_cnt)
  );

  function automatic logic [DW-1:0] alu_fn(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (c)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Environment's shared ALU.
  always_comb alu_out = alu_fn(alu_ctrl, alu_x1, alu_x2);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: the transaction pending at the consumer, who is favoured next, counts.
  bit          m_valid = 1'b0;
  bit          m_id = 1'b0;
  logic [DW-1:0] m_data = '0;
  bit          m_prio = 1'b0;
  int          m_c0 = 0, m_c1 = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit acc, g;
      logic [DW-1:0] ex1, ex2;
      logic [CW-1:0] ectl;
      acc = !rst && (!m_valid || rsp_ready) && (req0_valid || req1_valid);
      g = (req0_valid && req1_valid) ? m_prio : req1_valid;
      ex1 = '0; ex2 = '0; ectl = '0;
      if (acc) begin
        ex1  = g ? req1_x1 : req0_x1;
        ex2  = g ? req1_x2 : req0_x2;
        ectl = g ? req1_ctrl : req0_ctrl;
      end
      chk("req0_ready", 64'(req0_ready), 64'(acc && !g));
      chk("req1_ready", 64'(req1_ready), 64'(acc && g));
      chk("alu_x1", 64'(alu_x1), 64'(ex1));
      chk("alu_x2", 64'(alu_x2), 64'(ex2));
      chk("alu_ctrl", 64'(alu_ctrl), 64'(ectl));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk("rsp_data", 64'(rsp_data), 64'(m_data));
`ifdef ALU_ARB_STATS_EN
      chk("stat0_cnt", 64'(stat0_cnt), 64'(m_c0));
      chk("stat1_cnt", 64'(stat1_cnt), 64'(m_c1));
`else
      chk("stat0_cnt", 64'(stat0_cnt), 64'd0);
      chk("stat1_cnt", 64'(stat1_cnt), 64'd0);
`endif
      if (rst) begin
        m_valid = 1'b0; m_id = 1'b0; m_data = '0; m_prio = 1'b0; m_c0 = 0; m_c1 = 0;
      end else if (acc) begin
        m_valid = 1'b1;
        m_id = g;
        m_data = alu_fn(ectl, ex1, ex2);
        m_prio = !g;
        if (g) m_c1 = (m_c1 < 65535) ? m_c1 + 1 : 65535;
        else   m_c0 = (m_c0 < 65535) ? m_c0 + 1 : 65535;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [CW-1:0] rand_op();
    case ($urandom_range(0, 3))
      0: return OP_ADD;
      1: return OP_SUB;
      2: return OP_AND;
      default: return OP_XOR;
    endcase
  endfunction

  initial begin
    bit a0, a1;
    // Reset state
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_data", 64'(rsp_data), 64'd0);
    chk("reset stat0", 64'(stat0_cnt), 64'd0);

    // Single add 5+7 from req0
    step();
    rst = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_ctrl = OP_ADD; req0_x1 = 32'd5; req0_x2 = 32'd7;
    @(negedge clk);
    chk("add req0_ready", 64'(req0_ready), 64'd1);
    chk("add alu_x1", 64'(alu_x1), 64'd5);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("add rsp_valid", 64'(rsp_valid), 64'd1);
    chk("add rsp_id", 64'(rsp_id), 64'd0);
    chk("add rsp_data", 64'(rsp_data), 64'd12);

    // Alternating grants from reset under full contention
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    req0_valid = 1'b1; req0_ctrl = OP_ADD; req0_x1 = 32'd1;  req0_x2 = 32'd1;
    req1_valid = 1'b1; req1_ctrl = OP_SUB; req1_x1 = 32'd10; req1_x2 = 32'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr req0_ready", 64'(req0_ready), 64'(i % 2 == 0));
      chk("rr req1_ready", 64'(req1_ready), 64'(i % 2 == 1));
      if (i > 0) begin
        chk("rr rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rr rsp_id", 64'((i - 1) % 2), 64'(rsp_id));
        chk("rr rsp_data", 64'(rsp_data), (i % 2 == 1) ? 64'd2 : 64'd7);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("rr last rsp_id", 64'(rsp_id), 64'd1);
    step();

    // Back-pressure: held response, waiting sub 9-4
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_ctrl = OP_ADD; req0_x1 = 32'd1; req0_x2 = 32'd2;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_ctrl = OP_SUB; req1_x1 = 32'd9; req1_x2 = 32'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp rsp_data held", 64'(rsp_data), 64'd3);
      chk("bp rsp_id held", 64'(rsp_id), 64'd0);
      chk("bp req1_ready", 64'(req1_ready), 64'd0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp req1_ready drain", 64'(req1_ready), 64'd1);
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("bp rsp_data", 64'(rsp_data), 64'd5);
    chk("bp rsp_id", 64'(rsp_id), 64'd1);

    // Reset right after an accept discards the response and restores prio
    step();
    req0_valid = 1'b1; req0_ctrl = OP_ADD; req0_x1 = 32'd2; req0_x2 = 32'd2;
    step();
    rst = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("rst req0_ready", 64'(req0_ready), 64'd0);
    chk("rst req1_ready", 64'(req1_ready), 64'd0);
    chk("rst alu_x1", 64'(alu_x1), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post-rst req0 grant", 64'(req0_ready), 64'd1);
    chk("post-rst req1 grant", 64'(req1_ready), 64'd0);
    step();

    // Random traffic with occasional reset; requesters hold fields until accepted
    a0 = 1'b1; a1 = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!req0_valid || a0) begin
        req0_valid = $urandom_range(0, 2) != 0;
        req0_ctrl = rand_op(); req0_x1 = $urandom; req0_x2 = $urandom;
      end
      if (!req1_valid || a1) begin
        req1_valid = $urandom_range(0, 2) != 0;
        req1_ctrl = rand_op(); req1_x1 = $urandom; req1_x2 = $urandom;
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) == 0;
      @(negedge clk);
      a0 = req0_ready; a1 = req1_ready;
      step();
    end

    // Counter saturation: 70000 accepts from req0
    rst = 1'b1; req1_valid = 1'b0; req0_valid = 1'b0;
    step();
    rst = 1'b0; rsp_ready = 1'b1; req0_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      req0_ctrl = rand_op(); req0_x1 = $urandom; req0_x2 = $urandom;
      step();
    end
    req0_valid = 1'b0;
    @(negedge clk);
`ifdef ALU_ARB_STATS_EN
    chk("sat stat0", 64'(stat0_cnt), 64'hFFFF);
`else
    chk("sat stat0", 64'(stat0_cnt), 64'd0);
`endif
    chk("sat stat1", 64'(stat1_cnt), 64'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
